b1_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for the 3-in/4-out b1 logic cell (cell under test, CUT).
//  On start, drives all 8 input patterns {a,b,c}=0..7 for ROUNDS passes and compacts each response into a MISR.

---
 rtl/b1_bist_pkg.sv | 25 ++
 rtl/b1_golden_ref.sv | 17 +
 rtl/b1_bist_ctrl.sv | 155 +++++++++++++++
 tb/tb_b1_bist_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/b1_bist_pkg.sv
// Shared types and the reference behaviour of the b1 cell.
// Contents: state_t (IDLE/RUN/DONE), RESP_W, NPAT, and b1_ref(), which maps
// a pattern {a,b,c} to the expected response {pd,pe,pf,pg}.
package b1_bist_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int RESP_W = 4;
   localparam int NPAT   = 8;

   function automatic logic [RESP_W-1:0] b1_ref(input logic [2:0] pat);
      logic a;
      logic b;
      logic c;
      a = pat[2];
      b = pat[1];
      c = pat[0];
      return {c, a ^ b, (~a & ~b & c) | (a & b & ~c), ~c};
   endfunction

endpackage

// File: rtl/b1_golden_ref.sv
// Golden response model for the b1 cell. This is a combinational wrapper
// over b1_ref(), compiled only when B1_BIST_LOCAL_REF_EN is defined.
// Ports:
//   i_pattern  in  3  pattern {a,b,c}
//   o_resp     out 4  expected {pd,pe,pf,pg}
`ifdef B1_BIST_LOCAL_REF_EN
module b1_golden_ref
   import b1_bist_pkg::*;
(
   input  logic [2:0]        i_pattern,
   output logic [RESP_W-1:0] o_resp
);

   assign o_resp = b1_ref(i_pattern);

endmodule
`endif

// File: rtl/b1_bist_ctrl.sv
// BIST sequencer for the b1 logic cell. It walks all 8 input patterns for
// ROUNDS passes and compacts the responses into a MISR. At the end it
// reports the signature and a pass/fail result against GOLDEN.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start, abort          test request and cancel
//   cut_a/b/c             pattern driven into the cell
//   cut_d/e/f/g           cell response
//   busy, done            RUN indicator and 1-cycle completion pulse
//   sig, pass             last completed signature and its verdict
//   mismatch, fail_idx    only with B1_BIST_LOCAL_REF_EN: per-cycle compare
//                         against b1_golden_ref
//
// state | meaning
// IDLE  | waiting for start; CUT inputs held at 000
// RUN   | one pattern applied and captured per cycle
// DONE  | single-cycle completion; done=1, sig/pass just updated
module b1_bist_ctrl #(
   parameter int          ROUNDS = 1,
   parameter int          MISR_W = 16,
   parameter logic [15:0] POLY   = 16'h8016,
   parameter logic [15:0] SEED   = 16'hFFFF,
   parameter logic [15:0] GOLDEN = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              cut_a,
   output logic              cut_b,
   output logic              cut_c,
   input  logic              cut_d,
   input  logic              cut_e,
   input  logic              cut_f,
   input  logic              cut_g,
   output logic              busy,
   output logic              done,
   output logic [MISR_W-1:0] sig,
   output logic              pass
`ifdef B1_BIST_LOCAL_REF_EN
   ,
   output logic              mismatch,
   output logic [2:0]        fail_idx
`endif
);

   import b1_bist_pkg::*;

   localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [2:0]          r_pattern;
   logic [RW-1:0]       r_round;
   logic [MISR_W-1:0]   r_misr;
   logic [MISR_W-1:0]   r_sig;
   logic                r_pass;
   logic [RESP_W-1:0]   w_resp;
   logic [MISR_W-1:0]   w_misr_next;
   logic                w_last;
   logic                w_enter_run;
   logic                w_step;
   logic                w_pass_next;

   assign w_resp      = {cut_d, cut_e, cut_f, cut_g};
   assign w_misr_next = {r_misr[MISR_W-2:0], 1'b0}
                      ^ (r_misr[MISR_W-1] ? POLY[MISR_W-1:0] : {MISR_W{1'b0}})
                      ^ MISR_W'(w_resp);
   assign w_last      = (r_pattern == 3'd7) && (r_round == LAST_ROUND);
   assign w_enter_run = (r_state == IDLE) && start;
   // A capture happens on every RUN cycle unless that cycle is being aborted.
   assign w_step      = (r_state == RUN) && !abort;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN: begin
            if (abort)       w_state_next = IDLE;
            else if (w_last) w_state_next = DONE;
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pattern <= 3'd0;
         r_round   <= '0;
         r_misr    <= SEED[MISR_W-1:0];
         r_sig     <= '0;
         r_pass    <= 1'b0;
      end else if (w_enter_run) begin
         r_pattern <= 3'd0;
         r_round   <= '0;
         r_misr    <= SEED[MISR_W-1:0];
      end else if (w_step) begin
         r_pattern <= r_pattern + 3'd1;
         if (r_pattern == 3'd7) r_round <= r_round + RW'(1);
         r_misr <= w_misr_next;
         if (w_last) begin
            r_sig  <= w_misr_next;
            r_pass <= w_pass_next;
         end
      end
   end

`ifdef B1_BIST_LOCAL_REF_EN
   logic [RESP_W-1:0] w_ref;
   logic              w_diff;
   logic              r_mismatch;
   logic [2:0]        r_fail_idx;

   b1_golden_ref u_ref (
      .i_pattern (r_pattern),
      .o_resp    (w_ref)
   );

   assign w_diff = (w_ref != w_resp);
   // Include this cycle's compare so that a fault on the final pattern still fails.
   assign w_pass_next = (w_misr_next == GOLDEN[MISR_W-1:0]) && !(r_mismatch || w_diff);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mismatch <= 1'b0;
         r_fail_idx <= 3'd0;
      end else if (w_enter_run) begin
         r_mismatch <= 1'b0;
         r_fail_idx <= 3'd0;
      end else if (w_step && w_diff && !r_mismatch) begin
         r_mismatch <= 1'b1;
         r_fail_idx <= r_pattern;
      end
   end

   assign mismatch = r_mismatch;
   assign fail_idx = r_fail_idx;
`else
   assign w_pass_next = (w_misr_next == GOLDEN[MISR_W-1:0]);
`endif

   assign busy                  = (r_state == RUN);
   assign done                  = (r_state == DONE);
   assign {cut_a, cut_b, cut_c} = busy ? r_pattern : 3'b000;
   assign sig                   = r_sig;
   assign pass                  = r_pass;

endmodule

// File: tb/tb_b1_bist_ctrl.sv
module tb_b1_bist_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start1, abort1, start2, abort2, fault1, fault2;
   logic a1, b1, c1, d1, e1, f1, g1, busy1, done1, pass1;
   logic a2, b2, c2, d2, e2, f2, g2, busy2, done2, pass2;
   logic [15:0] sig1, sig2;
`ifdef B1_BIST_LOCAL_REF_EN
   logic mm1, mm2;
   logic [2:0] fi1, fi2;
`endif

   function automatic logic [3:0] cut_model(input logic [2:0] p, input logic flt);
      logic a, b, c, pd, pe, pf, pg;
      a = p[2]; b = p[1]; c = p[0];
      pd = c;
      pe = a ^ b;
      pf = (~a & ~b & c) | (a & b & ~c);
      pg = ~c;
      if (flt && p == 3'd6) pf = 1'b0;
      return {pd, pe, pf, pg};
   endfunction

   function automatic logic [15:0] model_sig(input int rounds, input logic flt);
      logic [15:0] m;
      logic [3:0]  r;
      m = 16'hFFFF;
      for (int k = 0; k < rounds; k++)
         for (int p = 0; p < 8; p++) begin
            r = cut_model(3'(p), flt);
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h8016 : 16'h0000) ^ {12'h000, r};
         end
      return m;
   endfunction

   localparam logic [15:0] GOLD1 = model_sig(1, 1'b0);
   localparam logic [15:0] GOLD2 = model_sig(2, 1'b0);

   assign {d1, e1, f1, g1} = cut_model({a1, b1, c1}, fault1);
   assign {d2, e2, f2, g2} = cut_model({a2, b2, c2}, fault2);

   b1_bist_ctrl #(.ROUNDS(1), .GOLDEN(GOLD1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1),
      .cut_a(a1), .cut_b(b1), .cut_c(c1),
      .cut_d(d1), .cut_e(e1), .cut_f(f1), .cut_g(g1),
      .busy(busy1), .done(done1), .sig(sig1), .pass(pass1)
`ifdef B1_BIST_LOCAL_REF_EN
      , .mismatch(mm1), .fail_idx(fi1)
`endif
   );

   b1_bist_ctrl #(.ROUNDS(2), .GOLDEN(GOLD2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2),
      .cut_a(a2), .cut_b(b2), .cut_c(c2),
      .cut_d(d2), .cut_e(e2), .cut_f(f2), .cut_g(g2),
      .busy(busy2), .done(done2), .sig(sig2), .pass(pass2)
`ifdef B1_BIST_LOCAL_REF_EN
      , .mismatch(mm2), .fail_idx(fi2)
`endif
   );

   // observation mux for the instance under test
   int cur = 1;
   logic        o_busy, o_done, o_pass;
   logic [2:0]  o_cut;
   logic [15:0] o_sig;
   always_comb begin
      o_busy = (cur == 1) ? busy1 : busy2;
      o_done = (cur == 1) ? done1 : done2;
      o_pass = (cur == 1) ? pass1 : pass2;
      o_cut  = (cur == 1) ? {a1, b1, c1} : {a2, b2, c2};
      o_sig  = (cur == 1) ? sig1 : sig2;
   end

   typedef struct {
      logic [15:0] sig;
      logic        pass;
      logic        flt;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      int          inst;
      int          rounds;
      logic        flt;
      logic [15:0] sig;
      logic        pass;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] last_sig;
   logic        last_pass;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_start(input logic v);
      if (cur == 1) start1 = v; else start2 = v;
   endtask

   task automatic sb_check(input string name);
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: done with empty scoreboard", name);
      end else begin
         n_cmp--;
         e = sb_q.pop_front();
         chk({name, "_sig"}, {16'h0, o_sig}, {16'h0, e.sig});
         chk({name, "_pass"}, {31'h0, o_pass}, {31'h0, e.pass});
`ifdef B1_BIST_LOCAL_REF_EN
         chk({name, "_mm"}, {31'h0, (cur == 1) ? mm1 : mm2}, {31'h0, e.flt});
         if (e.flt)
            chk({name, "_fidx"}, {29'h0, (cur == 1) ? fi1 : fi2}, 32'd6);
`endif
      end
   endtask

   // full test with cycle-exact checks of busy, CUT drive and the done pulse
   task automatic run_full(input int rounds, input logic flt,
                           input logic [15:0] esig, input logic epass);
      exp_t e;
      e.sig = esig; e.pass = epass; e.flt = flt;
      sb_q.push_back(e);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      for (int k = 0; k < 8 * rounds; k++) begin
         chk("run_busy", {31'h0, o_busy}, 32'd1);
         chk("run_cut", {29'h0, o_cut}, 32'(k % 8));
         chk("run_nodone", {31'h0, o_done}, 32'd0);
         @(negedge clk);
      end
      chk("done_pulse", {31'h0, o_done}, 32'd1);
      chk("done_busy", {31'h0, o_busy}, 32'd0);
      chk("done_cut", {29'h0, o_cut}, 32'd0);
      sb_check("result");
      @(negedge clk);
      chk("done_single", {31'h0, o_done}, 32'd0);
      last_sig  = esig;
      last_pass = epass;
   endtask

   vec_t vt[4];
   int   dones, first_done, prev_done;

   initial begin
      rst = 1'b1; start1 = 0; abort1 = 0; start2 = 0; abort2 = 0;
      fault1 = 0; fault2 = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy1", {31'h0, busy1}, 0);
      chk("rst_done1", {31'h0, done1}, 0);
      chk("rst_cut1", {29'h0, a1, b1, c1}, 0);
      chk("rst_sig1", {16'h0, sig1}, 0);
      chk("rst_pass1", {31'h0, pass1}, 0);
      chk("rst_busy2", {31'h0, busy2}, 0);
      chk("rst_sig2", {16'h0, sig2}, 0);
      rst = 1'b0;
      @(negedge clk);

      vt[0] = '{1, 1, 1'b0, model_sig(1, 1'b0), 1'b1};
      vt[1] = '{2, 2, 1'b0, model_sig(2, 1'b0), 1'b1};
      vt[2] = '{2, 2, 1'b1, model_sig(2, 1'b1), 1'b0};
      vt[3] = '{1, 1, 1'b1, model_sig(1, 1'b1), 1'b0};
      for (int i = 0; i < 4; i++) begin
         cur = vt[i].inst;
         fault1 = (cur == 1) ? vt[i].flt : 1'b0;
         fault2 = (cur == 2) ? vt[i].flt : 1'b0;
         run_full(vt[i].rounds, vt[i].flt, vt[i].sig, vt[i].pass);
         repeat (2) @(negedge clk);
      end
      cur = 1; fault1 = 0; fault2 = 0;

      // abort during the 4th RUN cycle
      start1 = 1; @(negedge clk); start1 = 0;
      repeat (3) @(negedge clk);
      chk("abort_pre_cut", {29'h0, o_cut}, 3);
      abort1 = 1; @(negedge clk); abort1 = 0;
      chk("abort_busy", {31'h0, o_busy}, 0);
      chk("abort_cut", {29'h0, o_cut}, 0);
      dones = 0;
      repeat (12) begin
         if (o_done) dones++;
         @(negedge clk);
      end
      // abort and start together: abort wins
      start1 = 1; @(negedge clk); start1 = 0; @(negedge clk);
      start1 = 1; abort1 = 1; @(negedge clk); start1 = 0; abort1 = 0;
      chk("abort_start_busy", {31'h0, o_busy}, 0);
      repeat (12) begin
         if (o_done) dones++;
         @(negedge clk);
      end
      chk("abort_nodone", dones, 0);
      chk("abort_sig_kept", {16'h0, o_sig}, {16'h0, last_sig});
      chk("abort_pass_kept", {31'h0, o_pass}, {31'h0, last_pass});

      // start during RUN and during DONE is ignored
      begin
         exp_t e;
         e.sig = GOLD1; e.pass = 1'b1; e.flt = 1'b0;
         sb_q.push_back(e);
      end
      dones = 0; first_done = -1;
      start1 = 1; @(negedge clk); start1 = 0;
      for (int i = 0; i < 30; i++) begin
         if (o_done) begin
            dones++;
            if (dones == 1) begin first_done = i; sb_check("ign"); end
         end
         start1 = (i == 3) || (o_done && dones == 1);
         @(negedge clk);
      end
      start1 = 0;
      chk("ign_dones", dones, 1);
      chk("ign_done_cycle", first_done, 8);

      // rst mid-RUN
      start1 = 1; @(negedge clk); start1 = 0;
      repeat (2) @(negedge clk);
      rst = 1; @(negedge clk); rst = 0;
      chk("mrst_busy", {31'h0, o_busy}, 0);
      chk("mrst_done", {31'h0, o_done}, 0);
      chk("mrst_cut", {29'h0, o_cut}, 0);
      chk("mrst_sig", {16'h0, o_sig}, 0);
      chk("mrst_pass", {31'h0, o_pass}, 0);
`ifdef B1_BIST_LOCAL_REF_EN
      chk("mrst_mm", {31'h0, mm1}, 0);
      chk("mrst_fi", {29'h0, fi1}, 0);
`endif
      @(negedge clk);
      run_full(1, 1'b0, GOLD1, 1'b1);

      // start held high across three tests
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.sig = GOLD1; e.pass = 1'b1; e.flt = 1'b0;
         sb_q.push_back(e);
      end
      dones = 0; prev_done = -1;
      start1 = 1; @(negedge clk);
      for (int i = 0; i < 45; i++) begin
         if (o_done) begin
            dones++;
            if (prev_done >= 0) chk("held_spacing", i - prev_done, 10);
            else chk("held_first", i, 8);
            prev_done = i;
            if (dones <= 3) sb_check("held");
            if (dones == 3) start1 = 0;
         end
         @(negedge clk);
      end
      start1 = 0;
      chk("held_dones", dones, 3);
      chk("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
